// File: rtl/i2c_mpu_target.sv
// I2C target modelling the MPU-6050 register interface: address match, auto-incrementing
// register pointer, open-drain ACK/read-data drive and a write strobe towards host logic.
module i2c_mpu_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h68,
  parameter int unsigned REG_DEPTH   = 128,
  parameter logic [7:0]  WHOAMI_ADDR = 8'h75
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int unsigned PW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StPtr      = 4'd3;
  localparam logic [3:0] StPtrAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StRdataAck = 4'd8;

  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;

  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          ack_q, ack_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          wr_en;

  logic [7:0]    regs [REG_DEPTH];
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;
  logic [PW-1:0] ptr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_in};
      sda_sync_q <= {sda_sync_q[1:0], sda_in};
    end
  end

  assign scl_s = scl_sync_q[1];
  assign scl_h = scl_sync_q[2];
  assign sda_s = sda_sync_q[1];
  assign sda_h = sda_sync_q[2];

  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

  assign rx_byte = {shift_q[6:0], sda_s};
  // WHOAMI is read-only and never stored in the register file
  assign rd_byte = (8'(ptr_q) == WHOAMI_ADDR) ? {1'b0, DEV_ADDR} : regs[ptr_q];
  assign ptr_inc = (ptr_q == PW'(REG_DEPTH - 1)) ? '0 : ptr_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    ack_d     = ack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en     = 1'b0;

    if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;

        StAddr: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = StAddrAck;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d  = StRdata;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = StPtr;
              sda_oe_d = 1'b0;
            end
          end
        end

        StPtr: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            ptr_d     = PW'(32'(shift_q) % REG_DEPTH);
            state_d   = StPtrAck;
            sda_oe_d  = 1'b1;
          end
        end

        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            state_d   = StWdata;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end
        end

        StWdata: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Commit on the last bit so an aborted byte never reaches the register file
            if (bit_cnt_q == 4'd7) begin
              ptr_d = ptr_inc;
              if (8'(ptr_q) != WHOAMI_ADDR) begin
                wr_en     = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = 8'(ptr_q);
                wr_data_d = rx_byte;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            state_d   = StWdataAck;
            sda_oe_d  = 1'b1;
          end
        end

        StRdata: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = StRdataAck;
              sda_oe_d = 1'b0;
              ptr_d    = ptr_inc;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        StRdataAck: begin
          if (scl_rise) begin
            ack_d = ~sda_s;
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (ack_q) begin
              state_d  = StRdata;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              // Master NACK: stay off the bus until the next START/STOP
              state_d  = StIdle;
              sda_oe_d = 1'b0;
            end
          end
        end

        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      ack_q     <= ack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: 8'h00};
    end else if (wr_en) begin
      regs[ptr_q] <= rx_byte;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
